// File: rtl/mux_4_to_1_if.sv
// Steering-mux bus: four packed input lanes plus a select code in, one
// selected lane out, each side carrying a valid qualifier.
interface mux_4_to_1_if #(
    parameter int DATA_W = 1
);
    logic [4*DATA_W-1:0] data_in;
    logic [1:0]          select;
    logic                in_valid;
    logic [DATA_W-1:0]   mux_out;
    logic                out_valid;

    modport master (
        output data_in,
        output select,
        output in_valid,
        input  mux_out,
        input  out_valid
    );

    modport slave (
        input  data_in,
        input  select,
        input  in_valid,
        output mux_out,
        output out_valid
    );
endinterface

// File: rtl/mux_4_to_1.sv
// 4:1 lane selector with a valid qualifier. The output is either registered
// (OUT_REG=1, one cycle of latency, holds when idle) or purely combinational.
module mux_4_to_1 #(
    parameter int DATA_W  = 1,
    parameter bit OUT_REG = 1'b1
) (
    input logic         clk,
    input logic         rst,
    mux_4_to_1_if.slave bus
);
    // Packed lane view: lanes[k] == data_in[k*DATA_W +: DATA_W].
    logic [3:0][DATA_W-1:0] lanes;
    logic [DATA_W-1:0]      sel_lane;

    assign lanes    = bus.data_in;
    assign sel_lane = lanes[bus.select];

    generate
        if (OUT_REG) begin : g_reg
            logic [DATA_W-1:0] out_q;
            logic              vld_q;

            // Reset dominates; an idle edge drops valid but keeps the data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_q <= '0;
                    vld_q <= 1'b0;
                end else begin
                    vld_q <= bus.in_valid;
                    if (bus.in_valid)
                        out_q <= sel_lane;
                end
            end

            assign bus.mux_out   = out_q;
            assign bus.out_valid = vld_q;
        end else begin : g_comb
            assign bus.mux_out   = sel_lane;
            assign bus.out_valid = bus.in_valid & ~rst;
        end
    endgenerate
endmodule

// File: tb/tb_mux_4_to_1.sv
// Checks the registered 1-bit build against a cycle-level reference model and
// the combinational 4-bit build against direct lane arithmetic.
module tb_mux_4_to_1;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mux_4_to_1_if #(.DATA_W(1)) ifc ();
    mux_4_to_1_if #(.DATA_W(4)) ifc4 ();

    mux_4_to_1 #(.DATA_W(1), .OUT_REG(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    logic rst_c;
    mux_4_to_1 #(.DATA_W(4), .OUT_REG(1'b0)) dut_c (
        .clk (clk),
        .rst (rst_c),
        .bus (ifc4.slave)
    );

    // Reference state for the registered build.
    logic m_out;
    logic m_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock of the registered build: drive at negedge, update the model at
    // the capture edge, compare at the following negedge.
    task automatic step(input string tag, input logic r, input logic [3:0] din,
                        input logic [1:0] sel, input logic vld);
        rst          = r;
        ifc.data_in  = din;
        ifc.select   = sel;
        ifc.in_valid = vld;
        @(posedge clk);
        if (r) begin
            m_out = 1'b0;
            m_vld = 1'b0;
        end else begin
            m_vld = vld;
            if (vld) m_out = 1'((din >> sel) & 4'h1);
        end
        @(negedge clk);
        chk({tag, ".out"}, 32'(ifc.mux_out), 32'(m_out));
        chk({tag, ".vld"}, 32'(ifc.out_valid), 32'(m_vld));
    endtask

    task automatic comb(input string tag, input logic r, input logic [15:0] din,
                        input logic [1:0] sel, input logic vld);
        logic [3:0] exp_lane;
        rst_c         = r;
        ifc4.data_in  = din;
        ifc4.select   = sel;
        ifc4.in_valid = vld;
        #1;
        exp_lane = 4'((din >> (int'(sel) * 4)) & 16'hF);
        chk({tag, ".out"}, 32'(ifc4.mux_out), 32'(exp_lane));
        chk({tag, ".vld"}, 32'(ifc4.out_valid), 32'(vld && !r));
    endtask

    initial begin
        logic [3:0] din;
        logic [1:0] sel;
        m_out = 1'b0;
        m_vld = 1'b0;
        rst = 1'b1;
        ifc.data_in = '0; ifc.select = '0; ifc.in_valid = 1'b0;
        rst_c = 1'b0;
        ifc4.data_in = '0; ifc4.select = '0; ifc4.in_valid = 1'b0;
        @(negedge clk);

        // Reset, then release with nothing valid.
        step("rst0", 1'b1, 4'hF, 2'd3, 1'b1);
        step("rst1", 1'b1, 4'hF, 2'd3, 1'b1);
        step("idle0", 1'b0, 4'hF, 2'd3, 1'b0);
        step("idle1", 1'b0, 4'hF, 2'd3, 1'b0);
        chk("idle.out0", 32'(ifc.mux_out), 32'h0);

        // Directed walk.
        step("walk0", 1'b0, 4'b0000, 2'b00, 1'b1);
        chk("walk0.abs", 32'(ifc.mux_out), 32'h0);
        step("walk1", 1'b0, 4'b1010, 2'b01, 1'b1);
        chk("walk1.abs", 32'(ifc.mux_out), 32'h1);
        step("walk2", 1'b0, 4'b1100, 2'b10, 1'b1);
        chk("walk2.abs", 32'(ifc.mux_out), 32'h1);
        step("walk3", 1'b0, 4'b0101, 2'b11, 1'b1);
        chk("walk3.abs", 32'(ifc.mux_out), 32'h0);

        // Exhaustive back-to-back.
        for (int d = 0; d < 16; d++)
            for (int s = 0; s < 4; s++)
                step("exh", 1'b0, 4'(d), 2'(s), 1'b1);

        // Hold while idle.
        step("hold.cap", 1'b0, 4'b1000, 2'b11, 1'b1);
        chk("hold.cap.abs", 32'(ifc.mux_out), 32'h1);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b0, 4'b0000, 2'b11, 1'b0);
            chk("hold.abs", 32'(ifc.mux_out), 32'h1);
        end

        // Mid-stream reset and resume.
        step("mrst.s0", 1'b0, 4'b1111, 2'b10, 1'b1);
        step("mrst.s1", 1'b0, 4'b1111, 2'b10, 1'b1);
        step("mrst.rst", 1'b1, 4'b1111, 2'b10, 1'b1);
        chk("mrst.abs", 32'(ifc.mux_out), 32'h0);
        step("mrst.res", 1'b0, 4'b1111, 2'b10, 1'b1);
        chk("mrst.res.abs", 32'(ifc.out_valid), 32'h1);

        // Glitch between edges must not be captured.
        rst = 1'b0; ifc.in_valid = 1'b0; ifc.data_in = 4'h0;
        #2 ifc.in_valid = 1'b1; ifc.data_in = 4'h0;
        #2 ifc.in_valid = 1'b0;
        step("glitch", 1'b0, 4'h0, 2'b10, 1'b0);

        // Randomized mix of reset, idle and capture.
        for (int i = 0; i < 300; i++) begin
            din = 4'($urandom);
            sel = 2'($urandom);
            step("rnd", ($urandom_range(0, 15) == 0), din, sel, 1'($urandom));
        end

        // Combinational 4-bit build.
        comb("c.dir", 1'b0, 16'hDCBA, 2'b10, 1'b1);
        comb("c.inv", 1'b0, 16'hDCBA, 2'b10, 1'b0);
        comb("c.rst", 1'b1, 16'hDCBA, 2'b10, 1'b1);
        for (int i = 0; i < 40; i++)
            comb("c.rnd", ($urandom_range(0, 7) == 0), 16'($urandom), 2'($urandom), 1'($urandom));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
